// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU control sequencer.
// Holds the state encoding shown on the board LEDs, the operation-select codes
// understood by the operations unit, and width helpers used by the top level.
package mpu_pkg;

    // State encoding; the numeric values are driven straight onto state_out.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5,
        ST_ABORT = 3'd6
    } mpu_state_e;

    // Operation-select codes for the operations unit.
    localparam int unsigned OP_ADD       = 0;
    localparam int unsigned OP_SUB       = 1;
    localparam int unsigned OP_MUL       = 2;
    localparam int unsigned OP_SCALE     = 3;
    localparam int unsigned OP_TRANSPOSE = 4;

    // Width of one whole matrix word.
    function automatic int unsigned mat_width(int unsigned elem_w, int unsigned dim);
        return elem_w * dim * dim;
    endfunction

    // Counter width able to hold the larger of the two load values.
    function automatic int unsigned cnt_width(int unsigned rd_lat, int unsigned timeout);
        int unsigned mx;
        mx = (rd_lat > timeout) ? rd_lat : timeout;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/mpu_cycle_counter.sv
// Loadable down-counter with a registered zero flag.
// Shared by the memory read-latency wait and the EXEC timeout.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   load_i        - load load_val_i (has priority over en_i)
//   load_val_i    - value to load
//   en_i          - decrement by one; saturates at zero
//   zero_o        - high while the count is zero
module mpu_cycle_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             zero_q;

    // Zero flag is kept registered alongside the count so consumers see no comb path.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            zero_q <= (load_val_i == '0);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            zero_q <= (cnt_q == CNT_W'(1));
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/mpu_sequencer.sv
// MPU control sequencer: fetches A and B from a synchronous single-port memory,
// launches the operations unit, waits for completion with a timeout, and writes
// the result back. Start/busy/done handshake toward the board I/O.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   start, op_code,
//   base_addr             - request; sampled only in IDLE (A@base, B@base+1, R@base+2)
//   busy, done, error     - status (done one-cycle pulse, error sticky timeout flag)
//   state_out             - current state encoding for LEDs
//   mem_addr, mem_wdata,
//   mem_wren, mem_rdata   - memory port
//   op_sel, op_a, op_b,
//   op_scalar, op_start   - operations unit launch
//   op_done, op_result    - operations unit completion
module mpu_sequencer
    import mpu_pkg::*;
#(
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned DIM        = 5,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned OP_W       = 3,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned OP_TIMEOUT = 255,
    localparam int unsigned MAT_W     = mat_width(ELEM_W, DIM)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op_code,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        state_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MAT_W-1:0]  mem_wdata,
    output logic              mem_wren,
    input  logic [MAT_W-1:0]  mem_rdata,
    output logic [OP_W-1:0]   op_sel,
    output logic [MAT_W-1:0]  op_a,
    output logic [MAT_W-1:0]  op_b,
    output logic [ELEM_W-1:0] op_scalar,
    output logic              op_start,
    input  logic              op_done,
    input  logic [MAT_W-1:0]  op_result
);

    localparam int unsigned CNT_W = cnt_width(RD_LAT, OP_TIMEOUT);
    // Read phases last RD_LAT+1 cycles: load RD_LAT and act on the zero cycle.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT);
    // EXEC lasts OP_TIMEOUT cycles including the op_start cycle.
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(OP_TIMEOUT - 1);

    mpu_state_e        state_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [MAT_W-1:0]  mem_wdata_q;
    logic              mem_wren_q;
    logic [OP_W-1:0]   op_sel_q;
    logic [MAT_W-1:0]  op_a_q;
    logic [MAT_W-1:0]  op_b_q;
    logic              op_start_q;

    logic [ADDR_W-1:0] addr_b_d;
    logic [ADDR_W-1:0] addr_r_d;

    logic              cnt_load;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;

    // Operand B and result addresses wrap modulo 2^ADDR_W.
    assign addr_b_d = base_q + ADDR_W'(1);
    assign addr_r_d = base_q + ADDR_W'(2);

    mpu_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    // Counter control: reload on each phase entry, count down while waiting.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_load = start;
                cnt_val  = RD_LOAD;
            end
            ST_RD_A: begin
                cnt_load = cnt_zero;
                cnt_en   = !cnt_zero;
                cnt_val  = RD_LOAD;
            end
            ST_RD_B: begin
                cnt_load = cnt_zero;
                cnt_en   = !cnt_zero;
                cnt_val  = TO_LOAD;
            end
            ST_EXEC: cnt_en = 1'b1;
            default: ;
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            op_sel_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_start_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            mem_wren_q <= 1'b0;
            op_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_sel_q   <= op_code;
                        base_q     <= base_addr;
                        mem_addr_q <= base_addr;
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    if (cnt_zero) begin
                        op_a_q     <= mem_rdata;
                        mem_addr_q <= addr_b_d;
                        state_q    <= ST_RD_B;
                    end
                end
                ST_RD_B: begin
                    if (cnt_zero) begin
                        op_b_q     <= mem_rdata;
                        op_start_q <= 1'b1;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // op_done in the launch cycle belongs to a previous operation.
                    if (!op_start_q && op_done) begin
                        mem_wdata_q <= op_result;
                        mem_addr_q  <= addr_r_d;
                        mem_wren_q  <= 1'b1;
                        state_q     <= ST_WR;
                    end else if (cnt_zero) begin
                        error_q <= 1'b1;
                        state_q <= ST_ABORT;
                    end
                end
                ST_WR: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE, ST_ABORT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign state_out = state_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign op_sel    = op_sel_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_scalar = op_b_q[ELEM_W-1:0];
    assign op_start  = op_start_q;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Directed bench for mpu_sequencer. Three instances share one clock:
//   0: RD_LAT=1, OP_TIMEOUT=16   1: RD_LAT=1, OP_TIMEOUT=4   2: RD_LAT=3, OP_TIMEOUT=16
// Each has its own memory model and operations-unit model.
// Cycle n of an operation is the n-th cycle after the edge that samples start.
module tb_mpu_sequencer;

    localparam int unsigned MAT_W = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]            rst;
    logic [2:0]            start;
    logic [2:0][2:0]       op_code;
    logic [2:0][2:0]       base;
    logic [2:0]            busy, done, error, mem_wren, op_start, op_done;
    logic [2:0][2:0]       state_out, mem_addr, op_sel;
    logic [2:0][MAT_W-1:0] mem_wdata, mem_rdata, op_a, op_b, op_result;
    logic [2:0][7:0]       op_scalar;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mpu_sequencer #(
            .ELEM_W     (8),
            .DIM        (5),
            .ADDR_W     (3),
            .OP_W       (3),
            .RD_LAT     ((g == 2) ? 3 : 1),
            .OP_TIMEOUT ((g == 1) ? 4 : 16)
        ) u_dut (
            .clock     (clk),
            .reset     (rst[g]),
            .start     (start[g]),
            .op_code   (op_code[g]),
            .base_addr (base[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .error     (error[g]),
            .state_out (state_out[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wren  (mem_wren[g]),
            .mem_rdata (mem_rdata[g]),
            .op_sel    (op_sel[g]),
            .op_a      (op_a[g]),
            .op_b      (op_b[g]),
            .op_scalar (op_scalar[g]),
            .op_start  (op_start[g]),
            .op_done   (op_done[g]),
            .op_result (op_result[g])
        );
    end

    // ---------------- memory model ----------------
    logic [MAT_W-1:0] mem [3][8];
    logic [2:0]       apipe [3][4];
    logic [2:0]       ld_en;
    logic [2:0][2:0]  ld_addr;
    logic [2:0][MAT_W-1:0] ld_data;

    function automatic int lat_of(int g);
        return (g == 2) ? 3 : 1;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (ld_en[g]) mem[g][ld_addr[g]] <= ld_data[g];
            else if (mem_wren[g]) mem[g][mem_addr[g]] <= mem_wdata[g];
            apipe[g][0] <= mem_addr[g];
            for (int k = 1; k < 4; k++) apipe[g][k] <= apipe[g][k-1];
        end
    end

    always_comb begin
        for (int g = 0; g < 3; g++) mem_rdata[g] = mem[g][apipe[g][lat_of(g)-1]];
    end

    // ---------------- operations-unit model ----------------
    // mode 0: op_done op_lat cycles after op_start; 1: never; 2: also a bogus op_done in the op_start cycle
    int op_lat [3];
    int op_mode [3];
    int op_cnt [3];

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (op_start[g]) begin
                op_cnt[g]    <= op_lat[g];
                op_done[g]   <= (op_mode[g] == 2);
                op_result[g] <= '1;
            end else if (op_cnt[g] > 1) begin
                op_cnt[g]  <= op_cnt[g] - 1;
                op_done[g] <= 1'b0;
            end else if (op_cnt[g] == 1) begin
                op_cnt[g]    <= 0;
                op_done[g]   <= (op_mode[g] != 1);
                op_result[g] <= op_a[g] + op_b[g] + MAT_W'(op_sel[g]);
            end else begin
                op_done[g] <= 1'b0;
            end
        end
    end

    // ---------------- event monitor ----------------
    int n_opst [3], n_wr [3], n_done [3], n_abort [3], n_badwr [3];
    int opst_cyc [3], wr_cyc [3], done_cyc [3], abort_cyc [3];
    logic [2:0] wr_addr [3], rda_addr [3], rdb_addr [3];

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (op_start[g]) begin n_opst[g] <= n_opst[g] + 1; opst_cyc[g] <= cyc; end
            if (mem_wren[g]) begin n_wr[g] <= n_wr[g] + 1; wr_cyc[g] <= cyc; wr_addr[g] <= mem_addr[g]; end
            if (done[g]) begin n_done[g] <= n_done[g] + 1; done_cyc[g] <= cyc; end
            if (state_out[g] == 3'd6) begin n_abort[g] <= n_abort[g] + 1; abort_cyc[g] <= cyc; end
            if (mem_wren[g] && state_out[g] != 3'd4) n_badwr[g] <= n_badwr[g] + 1;
            if (state_out[g] == 3'd1) rda_addr[g] <= mem_addr[g];
            if (state_out[g] == 3'd2) rdb_addr[g] <= mem_addr[g];
        end
    end

    // ---------------- helpers ----------------
    int total = 0;
    int bad = 0;

    function automatic logic [MAT_W-1:0] mk(int s);
        logic [MAT_W-1:0] r;
        for (int k = 0; k < 25; k++) r[k*8 +: 8] = 8'(s * 37 + k * 11 + 5);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int g, input logic [2:0] a, input logic [MAT_W-1:0] d);
        ld_en[g] = 1'b1; ld_addr[g] = a; ld_data[g] = d;
        step();
        ld_en[g] = 1'b0;
    endtask

    task automatic pulse_start(input int g, input logic [2:0] op, input logic [2:0] b, output int t0);
        op_code[g] = op; base[g] = b; start[g] = 1'b1;
        t0 = cyc;
        step();
        start[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n;
        n = 0;
        while (state_out[g] !== 3'd0 && n < budget) begin step(); n++; end
        total++;
        if (state_out[g] !== 3'd0) begin
            bad++; $display("FAIL wait_idle[%0d] state got %0d want 0 within %0d cycles", g, state_out[g], budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 3'b111;
        repeat (3) step();
        rst = 3'b000;
        total++; if (state_out[0] !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state_out[0]); end
        total++; if ({busy[0], done[0], error[0], mem_wren[0], op_start[0]} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got %b want 00000", {busy[0], done[0], error[0], mem_wren[0], op_start[0]}); end
        total++; if (mem_addr[0] !== 3'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", mem_addr[0]); end
        total++; if ({op_a[0], op_b[0], mem_wdata[0]} !== '0) begin bad++; $display("FAIL reset_data got nonzero want 0"); end
        total++; if (op_sel[0] !== 3'd0) begin bad++; $display("FAIL reset_opsel got %0d want 0", op_sel[0]); end
    endtask

    task automatic test_basic();
        int t0, b_opst;
        logic [MAT_W-1:0] a, b;
        a = mk(1); b = mk(2);
        load(0, 3'd0, a); load(0, 3'd1, b); load(0, 3'd2, '0);
        op_lat[0] = 3; op_mode[0] = 0;
        b_opst = n_opst[0];
        pulse_start(0, 3'd0, 3'd0, t0);
        total++; if (busy[0] !== 1'b1 || state_out[0] !== 3'd1) begin
            bad++; $display("FAIL basic_cycle1 busy/state got %b/%0d want 1/1", busy[0], state_out[0]); end
        wait_idle(0, 30);
        total++; if (n_opst[0] - b_opst !== 1 || opst_cyc[0] - t0 !== 5) begin
            bad++; $display("FAIL basic_opstart count/cycle got %0d/%0d want 1/5", n_opst[0] - b_opst, opst_cyc[0] - t0); end
        total++; if (wr_cyc[0] - t0 !== 9 || wr_addr[0] !== 3'd2) begin
            bad++; $display("FAIL basic_write cycle/addr got %0d/%0d want 9/2", wr_cyc[0] - t0, wr_addr[0]); end
        total++; if (done_cyc[0] - t0 !== 10) begin bad++; $display("FAIL basic_done_cycle got %0d want 10", done_cyc[0] - t0); end
        total++; if (mem[0][2] !== a + b) begin bad++; $display("FAIL basic_result got %h want %h", mem[0][2], a + b); end
        total++; if (op_a[0] !== a || op_b[0] !== b) begin bad++; $display("FAIL basic_operands got %h want %h", op_a[0], a); end
        total++; if (op_scalar[0] !== b[7:0]) begin bad++; $display("FAIL basic_scalar got %h want %h", op_scalar[0], b[7:0]); end
        total++; if (busy[0] !== 1'b0 || error[0] !== 1'b0) begin
            bad++; $display("FAIL basic_idle busy/error got %b/%b want 0/0", busy[0], error[0]); end
    endtask

    task automatic test_wrap();
        int t0;
        logic [MAT_W-1:0] a, b;
        a = mk(3); b = mk(4);
        load(0, 3'd7, a); load(0, 3'd0, b);
        op_lat[0] = 1; op_mode[0] = 0;
        pulse_start(0, 3'd5, 3'd7, t0);
        wait_idle(0, 30);
        total++; if (rda_addr[0] !== 3'd7 || rdb_addr[0] !== 3'd0) begin
            bad++; $display("FAIL wrap_read_addr got %0d,%0d want 7,0", rda_addr[0], rdb_addr[0]); end
        total++; if (wr_addr[0] !== 3'd1) begin bad++; $display("FAIL wrap_write_addr got %0d want 1", wr_addr[0]); end
        total++; if (mem[0][1] !== a + b + MAT_W'(5)) begin bad++; $display("FAIL wrap_result got %h want %h", mem[0][1], a + b + MAT_W'(5)); end
        total++; if (op_sel[0] !== 3'd5) begin bad++; $display("FAIL wrap_opsel got %0d want 5", op_sel[0]); end
    endtask

    task automatic test_timeout();
        int t0, b_ab, b_wr, b_dn;
        op_lat[1] = 3; op_mode[1] = 1;
        b_ab = n_abort[1]; b_wr = n_wr[1]; b_dn = n_done[1];
        pulse_start(1, 3'd1, 3'd4, t0);
        wait_idle(1, 40);
        total++; if (n_abort[1] - b_ab !== 1 || n_wr[1] - b_wr !== 0 || n_done[1] - b_dn !== 0) begin
            bad++; $display("FAIL timeout_counts abort/wr/done got %0d/%0d/%0d want 1/0/0",
                            n_abort[1] - b_ab, n_wr[1] - b_wr, n_done[1] - b_dn); end
        total++; if (abort_cyc[1] - t0 < 6 || abort_cyc[1] - t0 > 11) begin
            bad++; $display("FAIL timeout_abort_cycle got %0d want 6..11", abort_cyc[1] - t0); end
        total++; if (error[1] !== 1'b1 || busy[1] !== 1'b0) begin
            bad++; $display("FAIL timeout_error error/busy got %b/%b want 1/0", error[1], busy[1]); end
        repeat (2) step();
        total++; if (error[1] !== 1'b1) begin bad++; $display("FAIL timeout_sticky got %b want 1", error[1]); end
        op_lat[1] = 2; op_mode[1] = 0;
        b_dn = n_done[1];
        pulse_start(1, 3'd1, 3'd4, t0);
        total++; if (error[1] !== 1'b0) begin bad++; $display("FAIL timeout_clear got %b want 0", error[1]); end
        wait_idle(1, 40);
        total++; if (n_done[1] - b_dn !== 1 || error[1] !== 1'b0) begin
            bad++; $display("FAIL timeout_rerun done/error got %0d/%b want 1/0", n_done[1] - b_dn, error[1]); end
    endtask

    task automatic test_back_to_back();
        int t0, b_opst, b_wr, b_dn;
        op_lat[0] = 3; op_mode[0] = 0;
        b_opst = n_opst[0]; b_wr = n_wr[0]; b_dn = n_done[0];
        op_code[0] = 3'd1; base[0] = 3'd2; start[0] = 1'b1;
        t0 = cyc;
        // start held through the DONE cycle, released before IDLE samples it
        repeat (11) step();
        start[0] = 1'b0;
        repeat (5) step();
        total++; if (n_opst[0] - b_opst !== 1 || n_wr[0] - b_wr !== 1 || n_done[0] - b_dn !== 1) begin
            bad++; $display("FAIL b2b_counts opst/wr/done got %0d/%0d/%0d want 1/1/1",
                            n_opst[0] - b_opst, n_wr[0] - b_wr, n_done[0] - b_dn); end
        total++; if (done_cyc[0] - t0 !== 10) begin bad++; $display("FAIL b2b_done_cycle got %0d want 10", done_cyc[0] - t0); end
        total++; if (state_out[0] !== 3'd0 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL b2b_idle state/busy got %0d/%b want 0/0", state_out[0], busy[0]); end
    endtask

    task automatic test_reset_mid();
        int t0, b_wr;
        op_lat[0] = 3; op_mode[0] = 1;
        load(0, 3'd1, mk(8)); load(0, 3'd2, mk(9));
        b_wr = n_wr[0];
        pulse_start(0, 3'd6, 3'd1, t0);
        repeat (5) step();
        total++; if (state_out[0] !== 3'd3) begin bad++; $display("FAIL rstmid_exec got %0d want 3", state_out[0]); end
        rst[0] = 1'b1;
        step();
        total++; if (state_out[0] !== 3'd0 || {busy[0], done[0], error[0], mem_wren[0], op_start[0]} !== 5'b0) begin
            bad++; $display("FAIL rstmid_flags state/flags got %0d/%b want 0/00000",
                            state_out[0], {busy[0], done[0], error[0], mem_wren[0], op_start[0]}); end
        total++; if ({op_a[0], op_b[0], mem_wdata[0]} !== '0 || mem_addr[0] !== 3'd0 || op_sel[0] !== 3'd0) begin
            bad++; $display("FAIL rstmid_regs addr/sel got %0d/%0d want 0/0 with zero data", mem_addr[0], op_sel[0]); end
        rst[0] = 1'b0;
        repeat (20) step();
        total++; if (n_wr[0] - b_wr !== 0 || state_out[0] !== 3'd0) begin
            bad++; $display("FAIL rstmid_nowrite wr/state got %0d/%0d want 0/0", n_wr[0] - b_wr, state_out[0]); end
    endtask

    task automatic test_read_latency();
        int t0;
        logic [MAT_W-1:0] a, b;
        a = mk(5); b = mk(6);
        load(2, 3'd0, mk(7)); load(2, 3'd3, a); load(2, 3'd4, b); load(2, 3'd5, '0);
        op_lat[2] = 2; op_mode[2] = 2;
        pulse_start(2, 3'd2, 3'd3, t0);
        repeat (3) step();
        total++; if (state_out[2] !== 3'd1 || op_a[2] !== '0) begin
            bad++; $display("FAIL lat_cycle4 state got %0d want 1, op_a %h want 0", state_out[2], op_a[2]); end
        step();
        total++; if (state_out[2] !== 3'd2 || op_a[2] !== a || mem_addr[2] !== 3'd4) begin
            bad++; $display("FAIL lat_cycle5 state/addr got %0d/%0d want 2/4, op_a %h want %h", state_out[2], mem_addr[2], op_a[2], a); end
        repeat (3) step();
        total++; if (state_out[2] !== 3'd2 || op_b[2] !== '0) begin
            bad++; $display("FAIL lat_cycle8 state got %0d want 2, op_b %h want 0", state_out[2], op_b[2]); end
        step();
        total++; if (state_out[2] !== 3'd3 || op_start[2] !== 1'b1 || op_b[2] !== b) begin
            bad++; $display("FAIL lat_cycle9 state/op_start got %0d/%b want 3/1, op_b %h want %h", state_out[2], op_start[2], op_b[2], b); end
        wait_idle(2, 30);
        total++; if (done_cyc[2] - t0 !== 13 || wr_addr[2] !== 3'd5) begin
            bad++; $display("FAIL lat_done cycle/addr got %0d/%0d want 13/5", done_cyc[2] - t0, wr_addr[2]); end
        total++; if (mem[2][5] !== a + b + MAT_W'(2)) begin bad++; $display("FAIL lat_result got %h want %h", mem[2][5], a + b + MAT_W'(2)); end
    endtask

    initial begin
        rst = 3'b111; start = '0; op_code = '0; base = '0;
        ld_en = '0; ld_addr = '0; ld_data = '0;
        for (int g = 0; g < 3; g++) begin
            op_lat[g] = 1; op_mode[g] = 1; op_cnt[g] = 0;
            n_opst[g] = 0; n_wr[g] = 0; n_done[g] = 0; n_abort[g] = 0; n_badwr[g] = 0;
            opst_cyc[g] = 0; wr_cyc[g] = 0; done_cyc[g] = 0; abort_cyc[g] = 0;
        end
        op_done = '0; op_result = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_read_latency();
        total++; if (n_badwr[0] + n_badwr[1] + n_badwr[2] !== 0) begin
            bad++; $display("FAIL wren_outside_wr got %0d want 0", n_badwr[0] + n_badwr[1] + n_badwr[2]); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
